// File: rtl/alu_arb_pkg.sv
// Shared opcodes and FSM state encoding for the two-port ALU arbiter.
// No logic, so there is no latency and no backpressure.
// Optional per-requester grant counters are enabled with ALU_ARB_STATS_EN.
package alu_arb_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_INC = 3'b110;
  localparam logic [2:0] OP_DEC = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU with add/sub/and/or/xor/not/inc/dec, carry and zero flags.
// Zero latency; it has no handshake and no backpressure.
// Arithmetic ops take cout from the extra top bit, so a borrow reads as cout=1.
module alu_core
  import alu_arb_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
  output logic [WIDTH-1:0] y,
  output logic             cout,
  output logic             zero
);

  localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH:0] r;

  always_comb begin
    r = '0;
    case (sel)
      OP_ADD:  r = {1'b0, a} + {1'b0, b};
      OP_SUB:  r = {1'b0, a} - {1'b0, b};
      OP_AND:  r = {1'b0, a & b};
      OP_OR:   r = {1'b0, a | b};
      OP_XOR:  r = {1'b0, a ^ b};
      OP_NOT:  r = {1'b0, ~a};
      OP_INC:  r = {1'b0, a} + ONE;
      OP_DEC:  r = {1'b0, a} - ONE;
      default: r = '0;
    endcase
  end

  assign y    = r[WIDTH-1:0];
  assign cout = r[WIDTH];
  assign zero = (r[WIDTH-1:0] == '0);

endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one ALU between two valid/ready requesters; ALU_ARB_STATS_EN adds grant counters.
// Latency: result valid 1 cycle after the acceptance edge; one command in flight, issue interval >= 3 cycles.
// Backpressure: a held result (rsp_ready low) blocks all new grants until it is consumed.
module alu_rr_arbiter
  import alu_arb_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_sel,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_sel,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_y,
  output logic             rsp_cout,
  output logic             rsp_zero
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]      gnt_cnt0,
  output logic [15:0]      gnt_cnt1
`endif
);

  state_t           state, state_nxt;
  logic             last_gnt;
  logic             gnt0, gnt1;
  logic [WIDTH-1:0] op_a, op_b;
  logic [2:0]       op_sel;
  logic             op_id;
  logic [WIDTH-1:0] alu_y;
  logic             alu_cout, alu_zero;

  // rst_n gates the grant so no ready can escape while reset is held.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n && state == IDLE) begin
      if (req0_valid && req1_valid) begin
        gnt0 = last_gnt;
        gnt1 = !last_gnt;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt0 || gnt1) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt  <= 1'b1;
      op_a      <= '0;
      op_b      <= '0;
      op_sel    <= '0;
      op_id     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_y     <= '0;
      rsp_cout  <= 1'b0;
      rsp_zero  <= 1'b0;
    end else begin
      if (gnt0 || gnt1) begin
        op_a     <= gnt1 ? req1_a   : req0_a;
        op_b     <= gnt1 ? req1_b   : req0_b;
        op_sel   <= gnt1 ? req1_sel : req0_sel;
        op_id    <= gnt1;
        last_gnt <= gnt1;
      end
      if (state == EXEC) begin
        rsp_valid <= 1'b1;
        rsp_id    <= op_id;
        rsp_y     <= alu_y;
        rsp_cout  <= alu_cout;
        rsp_zero  <= alu_zero;
      end
      if (state == RESP && rsp_ready) rsp_valid <= 1'b0;
    end
  end

  alu_core #(.WIDTH(WIDTH)) u_alu_core (
    .a    (op_a),
    .b    (op_b),
    .sel  (op_sel),
    .y    (alu_y),
    .cout (alu_cout),
    .zero (alu_zero)
  );

`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else begin
      if (gnt0 && gnt_cnt0 != 16'hFFFF) gnt_cnt0 <= gnt_cnt0 + 16'd1;
      if (gnt1 && gnt_cnt1 != 16'hFFFF) gnt_cnt1 <= gnt_cnt1 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Scoreboard bench for alu_rr_arbiter: directed commands with hand-computed results, grant order and handshake rules.
module tb_alu_rr_arbiter;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] sel;
    logic [3:0] y;
    logic       c;
    logic       z;
  } cmd_t;

  typedef struct {
    logic       id;
    logic [3:0] y;
    logic       c;
    logic       z;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [3:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [2:0] req0_sel = '0, req1_sel = '0;
  logic       rsp_valid, rsp_ready = 1'b1, rsp_id, rsp_cout, rsp_zero;
  logic [3:0] rsp_y;
`ifdef ALU_ARB_STATS_EN
  logic [15:0] gnt_cnt0, gnt_cnt1;
`endif

  alu_rr_arbiter #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_y(rsp_y),
    .rsp_cout(rsp_cout), .rsp_zero(rsp_zero)
`ifdef ALU_ARB_STATS_EN
    , .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
`endif
  );

  always #5 clk = ~clk;

  cmd_t cmd0[$], cmd1[$];
  exp_t sb[$];
  int   gexp[$];
  int   checks = 0, errors = 0;
  int   acc_cnt = 0, cyc = 0, hs_cyc = -100;
  logic hs0 = 1'b0, hs1 = 1'b0;
  logic prev_valid = 1'b0, prev_ready = 1'b0, prev_rsp_hs = 1'b0;
  logic prev_id = 1'b0, prev_c = 1'b0, prev_z = 1'b0;
  logic [3:0] prev_y = '0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic cmd_t mk(input logic [3:0] a, input logic [3:0] b, input logic [2:0] sel,
                              input logic [3:0] y, input logic c, input logic z);
    cmd_t t;
    t.a = a; t.b = b; t.sel = sel; t.y = y; t.c = c; t.z = z;
    return t;
  endfunction

  task automatic accept(input int n);
    cmd_t t;
    exp_t e;
    if (n == 0) t = cmd0.pop_front();
    else        t = cmd1.pop_front();
    e.id = n[0]; e.y = t.y; e.c = t.c; e.z = t.z;
    sb.push_back(e);
    acc_cnt++;
    if (gexp.size() == 0) check("grant_unexpected", n, -1);
    else                  check("grant_order", n, gexp.pop_front());
  endtask

  // Driver: after each rising edge, retire handshaken commands and present the next one.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (hs0 && cmd0.size() > 0) accept(0);
      if (hs1 && cmd1.size() > 0) accept(1);
      req0_valid = (cmd0.size() > 0);
      if (cmd0.size() > 0) begin req0_a = cmd0[0].a; req0_b = cmd0[0].b; req0_sel = cmd0[0].sel; end
      req1_valid = (cmd1.size() > 0);
      if (cmd1.size() > 0) begin req1_a = cmd1[0].a; req1_b = cmd1[0].b; req1_sel = cmd1[0].sel; end
    end
  end

  // Monitor: samples on the falling edge, compares responses against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst_n) begin
      hs0 = 1'b0; hs1 = 1'b0;
      prev_valid = 1'b0; prev_ready = 1'b0; prev_rsp_hs = 1'b0;
    end else begin
      hs0 = req0_valid & req0_ready;
      hs1 = req1_valid & req1_ready;
      if (hs0 || hs1) hs_cyc = cyc;
      if (req0_ready && req1_ready) check("one_ready", 2, 1);
      if (rsp_valid && (req0_ready || req1_ready)) check("ready_while_rsp", 1, 0);
      if (prev_valid && !prev_ready) begin
        check("hold_valid", int'(rsp_valid), 1);
        check("hold_data", int'({rsp_id, rsp_y, rsp_cout, rsp_zero}), int'({prev_id, prev_y, prev_c, prev_z}));
      end
      if (rsp_valid && !prev_valid) check("latency", cyc - hs_cyc, 2);
      if (prev_rsp_hs && (req0_valid || req1_valid))
        check("grant_after_rsp", int'(req0_ready | req1_ready), 1);
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) check("unexpected_rsp", 1, 0);
        else begin
          e = sb.pop_front();
          check("rsp_id", int'(rsp_id), int'(e.id));
          check("rsp_y", int'(rsp_y), int'(e.y));
          check("rsp_cout", int'(rsp_cout), int'(e.c));
          check("rsp_zero", int'(rsp_zero), int'(e.z));
        end
      end
      prev_valid = rsp_valid; prev_ready = rsp_ready; prev_rsp_hs = rsp_valid & rsp_ready;
      prev_id = rsp_id; prev_y = rsp_y; prev_c = rsp_cout; prev_z = rsp_zero;
    end
  end

  task automatic wait_acc(input int n);
    int t = 0;
    while (acc_cnt < n && t < 100) begin @(posedge clk); #2; t++; end
    check("acc_timeout", int'(acc_cnt >= n), 1);
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((cmd0.size() > 0 || cmd1.size() > 0 || sb.size() > 0 || rsp_valid) && t < 200) begin
      @(negedge clk); t++;
    end
    check("drain_timeout", int'(t < 200), 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1);
  end

  initial begin
    int base;
    // Reset state, with a request already pending so ready gating is visible.
    cmd0.push_back(mk(4'd3, 4'd5, 3'b000, 4'd8, 1'b0, 1'b0)); gexp.push_back(0);
    repeat (3) @(posedge clk);
    #2;
    check("reset_rsp_valid", int'(rsp_valid), 0);
    check("reset_rsp_id", int'(rsp_id), 0);
    check("reset_rsp_y", int'(rsp_y), 0);
    check("reset_rsp_cout", int'(rsp_cout), 0);
    check("reset_rsp_zero", int'(rsp_zero), 0);
    check("reset_req0_ready", int'(req0_ready), 0);
    check("reset_req1_ready", int'(req1_ready), 0);
    rst_n = 1'b1;
    wait_drain();

    // Overflow then borrow.
    cmd0.push_back(mk(4'hF, 4'h1, 3'b000, 4'h0, 1'b1, 1'b1)); gexp.push_back(0);
    cmd0.push_back(mk(4'h2, 4'h5, 3'b001, 4'hD, 1'b1, 1'b0)); gexp.push_back(0);
    wait_drain();

    // Contention after reset: req0 first, then strict alternation.
    do_reset();
    cmd0.push_back(mk(4'hC, 4'hA, 3'b010, 4'h8, 1'b0, 1'b0));
    cmd0.push_back(mk(4'h5, 4'hA, 3'b011, 4'hF, 1'b0, 1'b0));
    cmd0.push_back(mk(4'hF, 4'hF, 3'b100, 4'h0, 1'b0, 1'b1));
    cmd1.push_back(mk(4'h5, 4'h0, 3'b101, 4'hA, 1'b0, 1'b0));
    cmd1.push_back(mk(4'h7, 4'h0, 3'b110, 4'h8, 1'b0, 1'b0));
    cmd1.push_back(mk(4'h0, 4'h0, 3'b111, 4'hF, 1'b1, 1'b0));
    for (int i = 0; i < 6; i++) gexp.push_back(i % 2);
    wait_drain();

    // Backpressure: result held while req1 waits.
    rsp_ready = 1'b0;
    base = acc_cnt;
    cmd0.push_back(mk(4'h9, 4'h3, 3'b001, 4'h6, 1'b0, 1'b0)); gexp.push_back(0);
    wait_acc(base + 1);
    cmd1.push_back(mk(4'h1, 4'h0, 3'b111, 4'h0, 1'b0, 1'b1)); gexp.push_back(1);
    repeat (6) @(posedge clk);
    #2;
    check("bp_rsp_valid", int'(rsp_valid), 1);
    check("bp_req1_ready", int'(req1_ready), 0);
    check("bp_req1_pending", int'(cmd1.size()), 1);
    rsp_ready = 1'b1;
    wait_drain();

    // Reset during EXEC discards the command.
    base = acc_cnt;
    cmd0.push_back(mk(4'h1, 4'h2, 3'b000, 4'h3, 1'b0, 1'b0)); gexp.push_back(0);
    wait_acc(base + 1);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("midop_rsp_valid", int'(rsp_valid), 0);
    check("midop_rsp_y", int'(rsp_y), 0);
    check("midop_readys", int'({req0_ready, req1_ready}), 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    check("midop_no_stale", int'(rsp_valid), 0);
    cmd0.push_back(mk(4'h7, 4'h9, 3'b000, 4'h0, 1'b1, 1'b1));
    cmd1.push_back(mk(4'h6, 4'h3, 3'b010, 4'h2, 1'b0, 1'b0));
    gexp.push_back(0); gexp.push_back(1);
    wait_drain();

    // Fresh reset, 3 req0 and 2 req1 transactions.
    do_reset();
    cmd0.push_back(mk(4'h1, 4'h1, 3'b000, 4'h2, 1'b0, 1'b0));
    cmd0.push_back(mk(4'h5, 4'h5, 3'b001, 4'h0, 1'b0, 1'b1));
    cmd0.push_back(mk(4'h0, 4'h0, 3'b011, 4'h0, 1'b0, 1'b1));
    cmd1.push_back(mk(4'h3, 4'h1, 3'b100, 4'h2, 1'b0, 1'b0));
    cmd1.push_back(mk(4'hF, 4'h0, 3'b101, 4'h0, 1'b0, 1'b1));
    for (int i = 0; i < 5; i++) gexp.push_back(i % 2);
    wait_drain();
`ifdef ALU_ARB_STATS_EN
    check("gnt_cnt0", int'(gnt_cnt0), 3);
    check("gnt_cnt1", int'(gnt_cnt1), 2);
`endif
    check("grants_left", gexp.size(), 0);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
- Shares one 4-bit ALU datapath (add/sub/and/or/xor/not/inc/dec, with carry and zero flags) between two requesters.
- Accepts valid/ready requests and arbitrates them round-robin.
- Registers the operands, executes one operation, then holds a tagged result on a valid/ready response port until it is consumed.
- Sits between the ALU core and two independent command sources.

Parameters:
- WIDTH, 4: operand and result width in bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  requester 0 has a command.
- req0_ready  output  1  requester 0 command accepted this cycle.
- req0_a  input  WIDTH  requester 0 operand A.
- req0_b  input  WIDTH  requester 0 operand B.
- req0_sel  input  3  requester 0 opcode.
- req1_valid  input  1  requester 1 has a command.
- req1_ready  output  1  requester 1 command accepted this cycle.
- req1_a  input  WIDTH  requester 1 operand A.
- req1_b  input  WIDTH  requester 1 operand B.
- req1_sel  input  3  requester 1 opcode.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts the result.
- rsp_id  output  1  index of the requester that owns the result.
- rsp_y  output  WIDTH  result.
- rsp_cout  output  1  carry/borrow flag.
- rsp_zero  output  1  result-is-zero flag.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, rsp_valid=0, rsp_id=0, rsp_y=0, rsp_cout=0, rsp_zero=0, last_gnt=1. req*_ready are 0 while in reset.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant logic is combinational. If exactly one reqN_valid is high, that requester is granted.
  - If both are high, grant the requester that is not last_gnt.
  - reqN_ready=1 for the granted requester only; at most one ready is high per cycle.
  - On reqN_valid & reqN_ready: latch a, b, sel and id=N; set last_gnt=N; go to EXEC.
  - If no valid is high: stay in IDLE with both readys at 0.
- EXEC:
  - Compute from the latched operands and register rsp_y/cout/zero/id.
  - Set rsp_valid=1 and go to RESP.
  - Both readys are 0.
- RESP:
  - Hold all rsp_* outputs stable.
  - On rsp_valid & rsp_ready: clear rsp_valid and go to IDLE. The next grant can happen on the following cycle.
  - Both readys are 0.
- Latency: acceptance edge to rsp_valid is 1 cycle. Minimum issue interval is 3 cycles with rsp_ready held high.
- Opcodes:
  - 000: y=a+b, cout=carry out of bit WIDTH.
  - 001: y=a-b, cout=bit WIDTH of the (WIDTH+1)-bit difference (1 when a<b).
  - 010: a&b. 011: a|b. 100: a^b. 101: ~a. For these four, cout=0.
  - 110: a+1, with carry as for add. 111: a-1, with borrow as for sub.
  - zero = (y==0) for every opcode.
- Wrap-around: 4'hF+1 → y=0, cout=1, zero=1. 4'h0-1 → y=F, cout=1, zero=0.
- Requester contract: valid and data stay stable until ready is seen. A valid dropped before ready is not an error; nothing is latched for it.
- The arbiter never reorders a response and never loses one. Backpressure on rsp_ready stalls all new grants.
- Reset mid-operation: an in-flight command or held result is discarded. No response is produced after reset release.

Optional Feature:
- Macro: ALU_ARB_STATS_EN.
- Defined:
  - Adds output ports gnt_cnt0 and gnt_cnt1 (16 bits each).
  - Each counter increments on its requester's accepted handshake and saturates at 16'hFFFF.
  - Both counters reset to 0.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Decomposition:
- Package alu_arb_pkg holds:
  - opcode localparams OP_ADD..OP_DEC (3'b000..3'b111);
  - state typedef/encoding IDLE=2'd0, EXEC=2'd1, RESP=2'd2.
- Sub-module alu_core: purely combinational. Inputs a, b, sel; outputs y, cout, zero, per the opcode table above (cout defined for every opcode).
- The arbiter instantiates alu_core once, fed by the latched operands.

Test Plan:
- Single request: req0 a=3, b=5, sel=000 → req0_ready pulses 1 cycle; 1 cycle later rsp_valid=1, id=0, y=8, cout=0, zero=0.
- Overflow and borrow: a=F, b=1, add → y=0, cout=1, zero=1. Then a=2, b=5, sub → y=D, cout=1.
- Contention: both valid continuously after reset → grants alternate 0,1,0,1 and rsp_id follows the same order. req0 wins first.
- Backpressure: rsp_ready=0 for 5 cycles with req1 pending → rsp_* stay stable, req1_ready stays 0; the grant occurs 1 cycle after the response handshake.
- Reset mid-op: assert rst_n=0 during EXEC → all outputs 0 immediately; after release there is no stale rsp_valid, and the first grant goes to req0.
- Stats (ALU_ARB_STATS_EN): 3 req0 and 2 req1 transactions → gnt_cnt0=3, gnt_cnt1=2.
